// File: rtl/rename_pkg.sv
// Shared sizes and index types for the register rename stage.
package rename_pkg;

  localparam int AR_NUM    = 32;
  localparam int AR_IDX    = 5;
  localparam int PR_SIZE   = 7;
  localparam int PR_ARRAY  = 128;
  // Physical registers below this index back x0..x31 at reset; the rest start free.
  localparam int FREE_BASE = 32;
  localparam int FREE_INIT = PR_ARRAY - FREE_BASE;

  typedef logic [PR_SIZE-1:0] preg_t;
  typedef logic [AR_IDX-1:0]  areg_t;
  typedef logic [PR_SIZE:0]   pcnt_t;

endpackage

// File: rtl/free_list_fifo.sv
// Circular free list of physical registers, preloaded with p32..p127 at reset.
module free_list_fifo
  import rename_pkg::*;
(
  input  logic  clk,
  input  logic  rstn,
  input  logic  push,
  input  preg_t push_data,
  input  logic  pop,
  output preg_t head_data,
  output pcnt_t count
);

  preg_t mem [PR_ARRAY];
  preg_t head;
  preg_t tail;
  logic  push_ok;
  logic  pop_ok;

  // A full list drops pushes; an empty list ignores pops (the caller never issues one).
  assign push_ok   = push && (count != pcnt_t'(PR_ARRAY));
  assign pop_ok    = pop && (count != '0);
  assign head_data = mem[head];

  // Storage: reset preload of ascending free registers, tail write on push.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < PR_ARRAY; i++)
        mem[i] <= (i < FREE_INIT) ? preg_t'(i + FREE_BASE) : '0;
    end else if (push_ok) begin
      mem[tail] <= push_data;
    end
  end

  // Pointers wrap naturally at 7 bits; occupancy is tracked separately.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head  <= '0;
      tail  <= preg_t'(FREE_INIT);
      count <= pcnt_t'(FREE_INIT);
    end else begin
      if (pop_ok)  head <= head + preg_t'(1);
      if (push_ok) tail <= tail + preg_t'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + pcnt_t'(1);
        2'b01:   count <= count - pcnt_t'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/register_rename.sv
// Single-issue rename stage: RAT lookup/update, free-list allocation and
// per-physical-register ready tracking for the issue queue.
module register_rename
  import rename_pkg::*;
(
  input  logic                clk,
  input  logic                rstn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [AR_IDX-1:0]   rs1_arch,
  input  logic [AR_IDX-1:0]   rs2_arch,
  input  logic [AR_IDX-1:0]   rd_arch,
  input  logic                rd_wen,
  input  logic                stall_in,
  output logic                out_valid,
  output logic [PR_SIZE-1:0]  rs1_phys,
  output logic [PR_SIZE-1:0]  rs2_phys,
  output logic [PR_SIZE-1:0]  rd_phys,
  output logic [PR_SIZE-1:0]  old_rd_phys,
  output logic                rd_wen_out,
  input  logic                wb_valid,
  input  logic [PR_SIZE-1:0]  wb_phys,
  input  logic                commit_valid,
  input  logic [PR_SIZE-1:0]  commit_old_phys,
  output logic [PR_ARRAY-1:0] preg_ready,
  output logic [PR_SIZE:0]    free_count
);

  preg_t rat [AR_NUM];
  preg_t fl_head;
  logic  alloc_p0;
  logic  fire_p0;
  logic  commit_push;

  // ---- stage p0: acceptance and allocation decision ----
  // x0 is never renamed, so a write to it consumes no free register.
  assign alloc_p0    = rd_wen && (rd_arch != '0);
  // Uses the registered count only: a same-cycle commit cannot feed an empty list.
  assign in_ready    = !stall_in && (!alloc_p0 || (free_count != '0));
  assign fire_p0     = in_valid && in_ready;
  assign commit_push = commit_valid && (commit_old_phys != '0);

  free_list_fifo u_free_list (
    .clk       (clk),
    .rstn      (rstn),
    .push      (commit_push),
    .push_data (commit_old_phys),
    .pop       (fire_p0 && alloc_p0),
    .head_data (fl_head),
    .count     (free_count)
  );

  // RAT: identity map at reset, new destination installed on allocation.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < AR_NUM; i++)
        rat[i] <= preg_t'(i);
    end else if (fire_p0 && alloc_p0) begin
      rat[rd_arch] <= fl_head;
    end
  end

  // Ready vector: architectural backing registers start ready, allocation clears, writeback sets.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      preg_ready <= {{(PR_ARRAY-FREE_BASE){1'b0}}, {FREE_BASE{1'b1}}};
    end else begin
      if (fire_p0 && alloc_p0)
        preg_ready[fl_head] <= 1'b0;
      if (wb_valid && (wb_phys != '0))
        preg_ready[wb_phys] <= 1'b1;
    end
  end

  // ---- stage p1: registered renamed instruction ----
  // Sources read the RAT before this instruction's own update.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid   <= 1'b0;
      rs1_phys    <= '0;
      rs2_phys    <= '0;
      rd_phys     <= '0;
      old_rd_phys <= '0;
      rd_wen_out  <= 1'b0;
    end else begin
      out_valid <= fire_p0;
      if (fire_p0) begin
        rs1_phys    <= rat[rs1_arch];
        rs2_phys    <= rat[rs2_arch];
        rd_phys     <= alloc_p0 ? fl_head : '0;
        old_rd_phys <= alloc_p0 ? rat[rd_arch] : '0;
        rd_wen_out  <= alloc_p0;
      end
    end
  end

endmodule

// File: tb/tb_register_rename.sv
// Directed bench for register_rename.
module tb_register_rename;

  logic         clk;
  logic         rstn;
  logic         in_valid;
  logic         in_ready;
  logic [4:0]   rs1_arch;
  logic [4:0]   rs2_arch;
  logic [4:0]   rd_arch;
  logic         rd_wen;
  logic         stall_in;
  logic         out_valid;
  logic [6:0]   rs1_phys;
  logic [6:0]   rs2_phys;
  logic [6:0]   rd_phys;
  logic [6:0]   old_rd_phys;
  logic         rd_wen_out;
  logic         wb_valid;
  logic [6:0]   wb_phys;
  logic         commit_valid;
  logic [6:0]   commit_old_phys;
  logic [127:0] preg_ready;
  logic [7:0]   free_count;

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] READY_RST = {96'b0, 32'hffff_ffff};

  register_rename dut (
    .clk             (clk),
    .rstn            (rstn),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .rs1_arch        (rs1_arch),
    .rs2_arch        (rs2_arch),
    .rd_arch         (rd_arch),
    .rd_wen          (rd_wen),
    .stall_in        (stall_in),
    .out_valid       (out_valid),
    .rs1_phys        (rs1_phys),
    .rs2_phys        (rs2_phys),
    .rd_phys         (rd_phys),
    .old_rd_phys     (old_rd_phys),
    .rd_wen_out      (rd_wen_out),
    .wb_valid        (wb_valid),
    .wb_phys         (wb_phys),
    .commit_valid    (commit_valid),
    .commit_old_phys (commit_old_phys),
    .preg_ready      (preg_ready),
    .free_count      (free_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; rs1_arch = 0; rs2_arch = 0; rd_arch = 0; rd_wen = 0;
    stall_in = 0; wb_valid = 0; wb_phys = 0; commit_valid = 0; commit_old_phys = 0;
  endtask

  task automatic set_instr(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                           input logic [4:0] d, input logic w);
    in_valid = v; rs1_arch = s1; rs2_arch = s2; rd_arch = d; rd_wen = w;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rstn = 0;
    repeat (2) step();
    rstn = 1;
    step();
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    total++; if (free_count !== 8'd96) begin bad++; $display("FAIL reset_free_count got=%0d exp=96", free_count); end
    total++; if (preg_ready !== READY_RST) begin bad++; $display("FAIL reset_preg_ready got=%h exp=%h", preg_ready, READY_RST); end
    total++; if ({rs1_phys, rs2_phys, rd_phys, old_rd_phys, rd_wen_out} !== 29'd0) begin
      bad++; $display("FAIL reset_phys_outs got=%0d/%0d/%0d/%0d/%0b exp=0", rs1_phys, rs2_phys, rd_phys, old_rd_phys, rd_wen_out); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
  endtask

  task automatic test_basic_add();
    apply_reset();
    set_instr(1, 5'd1, 5'd2, 5'd5, 1);
    step();
    set_instr(0, 0, 0, 0, 0);
    total++; if ({out_valid, rs1_phys, rs2_phys, rd_phys, old_rd_phys, rd_wen_out} !== {1'b1, 7'd1, 7'd2, 7'd32, 7'd5, 1'b1}) begin
      bad++; $display("FAIL add_outputs got=v%0b %0d %0d %0d %0d w%0b exp=v1 1 2 32 5 w1", out_valid, rs1_phys, rs2_phys, rd_phys, old_rd_phys, rd_wen_out); end
    total++; if (preg_ready[32] !== 1'b0) begin bad++; $display("FAIL add_ready32 got=%0b exp=0", preg_ready[32]); end
    total++; if (free_count !== 8'd95) begin bad++; $display("FAIL add_free_count got=%0d exp=95", free_count); end
    step();
    total++; if (out_valid !== 1'b0 || rd_phys !== 7'd32) begin
      bad++; $display("FAIL add_hold got=v%0b rd%0d exp=v0 rd32", out_valid, rd_phys); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    set_instr(1, 5'd3, 5'd3, 5'd3, 1);
    step();
    total++; if ({rs1_phys, rs2_phys, rd_phys, old_rd_phys} !== {7'd3, 7'd3, 7'd32, 7'd3}) begin
      bad++; $display("FAIL b2b_first got=%0d %0d %0d %0d exp=3 3 32 3", rs1_phys, rs2_phys, rd_phys, old_rd_phys); end
    step();
    set_instr(0, 0, 0, 0, 0);
    total++; if ({out_valid, rs1_phys, rs2_phys, rd_phys, old_rd_phys} !== {1'b1, 7'd32, 7'd32, 7'd33, 7'd32}) begin
      bad++; $display("FAIL b2b_second got=v%0b %0d %0d %0d %0d exp=v1 32 32 33 32", out_valid, rs1_phys, rs2_phys, rd_phys, old_rd_phys); end
    total++; if (free_count !== 8'd94) begin bad++; $display("FAIL b2b_free_count got=%0d exp=94", free_count); end
  endtask

  task automatic test_x0_and_wb();
    apply_reset();
    set_instr(1, 5'd1, 5'd1, 5'd5, 1);
    step();
    set_instr(1, 5'd4, 5'd5, 5'd0, 1);
    step();
    set_instr(0, 0, 0, 0, 0);
    total++; if ({out_valid, rs2_phys, rd_phys, old_rd_phys, rd_wen_out} !== {1'b1, 7'd32, 7'd0, 7'd0, 1'b0}) begin
      bad++; $display("FAIL x0_outputs got=v%0b rs2=%0d rd=%0d old=%0d w%0b exp=v1 32 0 0 w0", out_valid, rs2_phys, rd_phys, old_rd_phys, rd_wen_out); end
    total++; if (free_count !== 8'd95) begin bad++; $display("FAIL x0_free_count got=%0d exp=95", free_count); end
    wb_valid = 1; wb_phys = 7'd32;
    #1;
    total++; if (preg_ready[32] !== 1'b0) begin bad++; $display("FAIL wb_before_edge got=%0b exp=0", preg_ready[32]); end
    step();
    wb_valid = 0; wb_phys = 0;
    total++; if (preg_ready[32] !== 1'b1) begin bad++; $display("FAIL wb_ready32 got=%0b exp=1", preg_ready[32]); end
  endtask

  task automatic test_exhaust();
    int errs;
    errs = 0;
    apply_reset();
    for (int i = 0; i < 96; i++) begin
      set_instr(1, 0, 0, 5'((i % 31) + 1), 1);
      step();
      if (rd_phys !== 7'(32 + i) || out_valid !== 1'b1) errs++;
    end
    total++; if (errs != 0) begin bad++; $display("FAIL exhaust_alloc_seq got=%0d bad allocations exp=0", errs); end
    total++; if (free_count !== 8'd0) begin bad++; $display("FAIL exhaust_empty got=%0d exp=0", free_count); end
    set_instr(1, 0, 0, 5'd2, 1);
    commit_valid = 1; commit_old_phys = 7'd5;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL exhaust_in_ready got=%0b exp=0", in_ready); end
    step();
    commit_valid = 0; commit_old_phys = 0;
    total++; if (out_valid !== 1'b0 || free_count !== 8'd1) begin
      bad++; $display("FAIL exhaust_stall got=v%0b fc%0d exp=v0 fc1", out_valid, free_count); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL exhaust_unblock got=%0b exp=1", in_ready); end
    step();
    set_instr(0, 0, 0, 0, 0);
    total++; if (out_valid !== 1'b1 || rd_phys !== 7'd5 || free_count !== 8'd0) begin
      bad++; $display("FAIL exhaust_reuse got=v%0b rd%0d fc%0d exp=v1 rd5 fc0", out_valid, rd_phys, free_count); end
    commit_valid = 1; commit_old_phys = 7'd7;
    step();
    total++; if (free_count !== 8'd1) begin bad++; $display("FAIL exhaust_commit7 got=%0d exp=1", free_count); end
    set_instr(1, 0, 0, 5'd9, 1);
    commit_old_phys = 7'd8;
    step();
    set_instr(0, 0, 0, 0, 0);
    commit_valid = 0; commit_old_phys = 0;
    total++; if (rd_phys !== 7'd7 || free_count !== 8'd1) begin
      bad++; $display("FAIL push_pop_same got=rd%0d fc%0d exp=rd7 fc1", rd_phys, free_count); end
    set_instr(1, 0, 0, 5'd9, 1);
    step();
    set_instr(0, 0, 0, 0, 0);
    total++; if (rd_phys !== 7'd8 || free_count !== 8'd0) begin
      bad++; $display("FAIL push_pop_next got=rd%0d fc%0d exp=rd8 fc0", rd_phys, free_count); end
  endtask

  task automatic test_wrap();
    logic [6:0] q[$];
    logic [6:0] rat [32];
    logic [6:0] exp_new, exp_old, prev_old;
    logic [4:0] rd;
    int errs;
    errs = 0;
    prev_old = 0;
    apply_reset();
    for (int i = 32; i < 128; i++) q.push_back(7'(i));
    for (int i = 0; i < 32; i++) rat[i] = 7'(i);
    for (int i = 0; i < 200; i++) begin
      rd = 5'((i % 31) + 1);
      exp_new = q.pop_front();
      exp_old = rat[rd];
      rat[rd] = exp_new;
      set_instr(1, rd, 5'd0, rd, 1);
      commit_valid = (i > 0);
      if (i > 0 && (i % 17) == 0) begin
        commit_old_phys = 7'd0;
      end else begin
        commit_old_phys = prev_old;
        if (i > 0) q.push_back(prev_old);
      end
      step();
      if (rd_phys !== exp_new || old_rd_phys !== exp_old || rs1_phys !== exp_old) begin
        errs++;
        if (errs < 4) $display("FAIL wrap_iter%0d got=rd%0d old%0d exp=rd%0d old%0d", i, rd_phys, old_rd_phys, exp_new, exp_old);
      end
      prev_old = exp_old;
    end
    set_instr(0, 0, 0, 0, 0);
    commit_valid = 0; commit_old_phys = 0;
    step();
    total++; if (errs != 0) begin bad++; $display("FAIL wrap_sequence got=%0d bad iterations exp=0", errs); end
    total++; if (free_count !== 8'(q.size())) begin bad++; $display("FAIL wrap_free_count got=%0d exp=%0d", free_count, q.size()); end
    stall_in = 1;
    set_instr(1, 0, 0, 0, 0);
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready got=%0b exp=0", in_ready); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_out_valid got=%0b exp=0", out_valid); end
    stall_in = 0;
    set_instr(0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    set_instr(1, 5'd1, 5'd2, 5'd6, 1);
    step(); step(); step();
    #2;
    rstn = 0;
    #1;
    total++; if ({out_valid, rd_phys, rd_wen_out} !== 9'd0 || free_count !== 8'd96) begin
      bad++; $display("FAIL midreset_outs got=v%0b rd%0d w%0b fc%0d exp=v0 rd0 w0 fc96", out_valid, rd_phys, rd_wen_out, free_count); end
    total++; if (preg_ready !== READY_RST) begin bad++; $display("FAIL midreset_ready got=%h exp=%h", preg_ready, READY_RST); end
    set_instr(0, 0, 0, 0, 0);
    step();
    rstn = 1;
    set_instr(1, 5'd6, 5'd0, 5'd6, 1);
    step();
    set_instr(0, 0, 0, 0, 0);
    total++; if (rd_phys !== 7'd32 || old_rd_phys !== 7'd6 || rs1_phys !== 7'd6) begin
      bad++; $display("FAIL midreset_alloc got=rd%0d old%0d rs1%0d exp=rd32 old6 rs1_6", rd_phys, old_rd_phys, rs1_phys); end
  endtask

  initial begin
    idle_inputs();
    rstn = 0;
    test_reset();
    test_basic_add();
    test_back_to_back();
    test_x0_and_wb();
    test_exhaust();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/register_rename.md
# register_rename

Rename stage feeding the unified issue queue. Each cycle it accepts at most one decoded instruction. It maps architectural sources and destination onto physical registers through a register alias table (RAT), allocates new destinations from a free-list FIFO, and keeps the per-physical-register ready vector that the issue queue consumes as its source-ready inputs. Writeback sets ready bits, and commit returns superseded physical registers to the free list.

## Interface
- `AR_NUM`, 32, architectural registers (x0..x31)
- `AR_IDX`, 5, architectural index width
- `PR_SIZE`, 7, physical register index width
- `PR_ARRAY`, 128, physical register count
- `clk`  in  1  clock, rising edge
- `rstn`  in  1  reset, asynchronous, active-low
- `in_valid`  in  1  decoded instruction present
- `in_ready`  out  1  combinational: instruction accepted this cycle if `in_valid`
- `rs1_arch`, `rs2_arch`, `rd_arch`  in  AR_IDX  architectural operands
- `rd_wen`  in  1  instruction writes `rd_arch`
- `stall_in`  in  1  issue queue full, consumes nothing next cycle
- `out_valid`  out  1  renamed instruction valid (registered)
- `rs1_phys`, `rs2_phys`, `rd_phys`, `old_rd_phys`  out  PR_SIZE  renamed operands; `old_rd_phys` is the previous mapping of `rd_arch`
- `rd_wen_out`  out  1  registered copy of effective `rd_wen`
- `wb_valid`  in  1  writeback event
- `wb_phys`  in  PR_SIZE  physical register written
- `commit_valid`  in  1  commit event
- `commit_old_phys`  in  PR_SIZE  register to free
- `preg_ready`  out  PR_ARRAY  bit p = 1 when physical register p holds valid data; drives the issue queue's `rs1_ready_in` and `rs2_ready_in`
- `free_count`  out  PR_SIZE+1  free-list occupancy

## Operation
- Effective write: `alloc = rd_wen && rd_arch != 0`. x0 is never renamed and always maps to p0.
- Acceptance:
  - `in_ready = !stall_in && (!alloc || free_count != 0)`.
  - `fire = in_valid && in_ready`.
- On fire:
  - `rs1_phys`/`rs2_phys` read the RAT before this instruction's own update, so `rd == rs1` yields the old mapping.
  - If `alloc`: pop the free-list head into `rd_phys`, `old_rd_phys <= RAT[rd_arch]`, `RAT[rd_arch] <= new`, `preg_ready[new] <= 0`.
  - If not `alloc`: `rd_phys = 0`, `old_rd_phys = 0`, `rd_wen_out = 0`.
- Writeback: `wb_valid` sets `preg_ready[wb_phys] <= 1`. `wb_phys == 0` has no effect.
- Commit: `commit_valid && commit_old_phys != 0` pushes `commit_old_phys` at the free-list tail.
- Free list: 128-deep circular FIFO with 7-bit head/tail pointers that wrap naturally; `free_count` is held separately. A push when `free_count == PR_ARRAY` is dropped, and a pop is impossible when empty (blocked by `in_ready`).
- Simultaneous events:
  - Push and pop in the same cycle: `free_count` unchanged.
  - A same-cycle commit does not bypass into an allocation when `free_count == 0`; the instruction stalls one cycle.
  - Writeback and allocation never target the same register.
  - Writeback and commit to different registers proceed independently.
- No state machine; state is RAT, free list, pointers, count and `preg_ready`.

## Timing
- Latency: one cycle. Fire at edge N puts the renamed outputs and `out_valid=1` after edge N. With no fire, `out_valid <= 0` and the other outputs hold.
- Free-list, RAT and `preg_ready` updates become visible after the edge.
- Reset (asynchronous, any time, including mid-stream):
  - `RAT[i] = i`.
  - Free list holds p32..p127 in ascending order: head=0, tail=96, `free_count=96`.
  - `preg_ready[31:0] = 1`, `[127:32] = 0`.
  - `out_valid=0`; all phys outputs 0; `rd_wen_out=0`.
- `in_ready` depends combinationally on `stall_in`, `rd_wen`, `rd_arch` and registered count only.

## Structure
- Package `rename_pkg`: `AR_IDX`, `PR_SIZE`, `PR_ARRAY`, `AR_NUM`, reset free-list base (32), `preg_t` / `areg_t` index typedefs.
- Sub-module `free_list_fifo`: push/pop ports, count, reset preload of 32..127. The RAT and ready vector stay in the top level.

## Test plan
- Reset then `add x5,x1,x2` (`rd_wen=1`): `rs1_phys=1`, `rs2_phys=2`, `rd_phys=32`, `old_rd_phys=5`, `preg_ready[32]=0`, `free_count=95`.
- Back-to-back `x3=x3+x3` twice: first gives `rs1_phys=3`, `rd_phys=32`; second gives `rs1_phys=32`, `rd_phys=33`, `old_rd_phys=32`.
- `rd_arch=0` with `rd_wen=1`: `rd_phys=0`, `rd_wen_out=0`, `free_count` unchanged. Then `wb_valid`, `wb_phys=32` gives `preg_ready[32]=1` one cycle later.
- Exhaust all 96 free registers:
  - 97th write stalls with `in_ready=0` and `out_valid=0`.
  - A commit of p5 that cycle does not unblock it; it fires next cycle with `rd_phys=5`.
  - Push and pop in the same cycle keep `free_count` constant.
- 200 alloc+commit pairs: the head pointer wraps 127 to 0 with no lost or duplicated register; commits of p0 are ignored. `stall_in=1` forces `in_ready=0`.
- Assert `rstn` low mid-stream: everything returns to reset values asynchronously, and the next allocation returns p32.
